// File: rtl/uart_echo_link.sv
// Sends a command byte through uart_tx, waits for the echo on uart_rx and retries on failure.
// Define UART_ECHO_STATS_EN to add saturating stat_ok/stat_fail/stat_retry counters.
module uart_echo_link #(
  parameter int unsigned TIMEOUT_CYCLES = 24000000,
  parameter int unsigned GAP_CYCLES     = 48000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic [7:0]  data_to_tx,
  output logic        start_tx,
  input  logic        tx_busy,
  input  logic [7:0]  data_received,
  input  logic        rx_done,
  input  logic        parity_error,
  output logic        done,
  output logic        pass,
  output logic [1:0]  retries_used,
  output logic [1:0]  err_code
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_fail,
  output logic [15:0] stat_retry
`endif
);

  // cmd_valid/cmd_ready: a byte is taken on any clock where both are high. cmd_ready is
  // high only in IDLE; requests made while busy are dropped, never queued.

  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRIES);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_PARITY   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_TX_WAIT   = 3'd2,
    ST_ECHO_WAIT = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             pass_q, pass_d;
  logic [1:0]       err_q, err_d;
  logic             fail_now;
  logic [1:0]       fail_code;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    retry_d   = retry_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          retry_d = '0;
          err_d   = ERR_NONE;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = ST_ECHO_WAIT;
        end
      end
      ST_ECHO_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // An echo landing on the timeout clock still counts as an echo.
        if (rx_done) begin
          if (parity_error) begin
            fail_now  = 1'b1;
            fail_code = ERR_PARITY;
          end else if (data_received != data_q) begin
            fail_now  = 1'b1;
            fail_code = ERR_MISMATCH;
          end else begin
            pass_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_FINISH;
          end
        end else if (cnt_q == TO_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
        if (fail_now) begin
          err_d = fail_code;
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_GAP;
          end else begin
            pass_d  = 1'b0;
            state_d = ST_FINISH;
          end
        end
      end
      ST_GAP: begin
        // Late echoes arriving here are dropped on purpose.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      retry_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign start_tx   = (state_q == ST_SEND);
  assign done       = (state_q == ST_FINISH);
  assign data_to_tx = data_q;
  assign pass       = pass_q;
  assign err_code   = err_q;

  always_comb begin
    retries_used = 2'd3;
    if (32'(retry_q) < 32'd3) retries_used = 2'(retry_q);
  end

`ifdef UART_ECHO_STATS_EN
  logic [15:0] ok_q, ok_d, fail_q, fail_d, rty_q, rty_d;

  always_comb begin
    ok_d   = ok_q;
    fail_d = fail_q;
    rty_d  = rty_q;
    if (state_q == ST_ECHO_WAIT && state_d == ST_FINISH) begin
      if (pass_d) begin
        if (ok_q != 16'hFFFF) ok_d = ok_q + 16'd1;
      end else begin
        if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
      end
    end
    if (state_q == ST_ECHO_WAIT && state_d == ST_GAP && rty_q != 16'hFFFF) begin
      rty_d = rty_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_q   <= 16'h0000;
      fail_q <= 16'h0000;
      rty_q  <= 16'h0000;
    end else begin
      ok_q   <= ok_d;
      fail_q <= fail_d;
      rty_q  <= rty_d;
    end
  end

  assign stat_ok    = ok_q;
  assign stat_fail  = fail_q;
  assign stat_retry = rty_q;
`endif

endmodule

// File: tb/tb_uart_echo_link.sv
// Randomized bench for uart_echo_link: a driver plays the uart_tx/uart_rx side from a
// per-attempt plan, and a monitor checks results and timing against a plan-level model.
module tb_uart_echo_link;

  localparam int T  = 100;
  localparam int G  = 20;
  localparam int MR = 3;

  localparam int B_GOOD = 0;
  localparam int B_MIS  = 1;
  localparam int B_PAR  = 2;
  localparam int B_TO   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic [7:0] data_received = 8'h00;
  logic       rx_done = 1'b0;
  logic       parity_error = 1'b0;
  logic       cmd_ready, start_tx, done, pass;
  logic [7:0] data_to_tx;
  logic [1:0] retries_used, err_code;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] stat_ok, stat_fail, stat_retry;
`endif

  uart_echo_link #(
    .TIMEOUT_CYCLES(T),
    .GAP_CYCLES(G),
    .MAX_RETRIES(MR),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .data_to_tx(data_to_tx),
    .start_tx(start_tx),
    .tx_busy(tx_busy),
    .data_received(data_received),
    .rx_done(rx_done),
    .parity_error(parity_error),
    .done(done),
    .pass(pass),
    .retries_used(retries_used),
    .err_code(err_code)
`ifdef UART_ECHO_STATS_EN
    ,
    .stat_ok(stat_ok),
    .stat_fail(stat_fail),
    .stat_retry(stat_retry)
`endif
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [4:0] exp_q[$];          // {pass, retries_used, err_code}
  int         exp_start_cyc_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_done_cyc_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic       start_prev = 1'b0;
  logic       done_prev = 1'b0;
  int         plan[8];
  bit         force_d = 1'b0;
  int         exp_ok = 0, exp_fail = 0, exp_retry = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] code_of(input int b);
    case (b)
      B_MIS:   return 2'b10;
      B_PAR:   return 2'b11;
      B_TO:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Reference: attempts run until the first good echo, at most MR+1 of them.
  function automatic logic [4:0] ref_result(output int n_att);
    logic       ok;
    logic [1:0] err;
    int         r;
    ok = 1'b0;
    err = 2'b00;
    n_att = 0;
    for (int i = 0; i <= MR; i++) begin
      n_att++;
      if (plan[i] == B_GOOD) begin
        ok = 1'b1;
        break;
      end
      err = code_of(plan[i]);
    end
    r = (n_att - 1 > 3) ? 3 : n_att - 1;
    return {ok, 2'(r), err};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (start_tx && !start_prev) begin
        if (exp_start_cyc_q.size() == 0) begin
          check("unexpected_start", start_tx, 0);
        end else begin
          check("start_cycle", cyc, exp_start_cyc_q.pop_front());
          check("start_byte", data_to_tx, exp_byte_q.pop_front());
        end
      end
      if (done) begin
        check("done_one_cycle", done_prev, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          check("pass", pass, exp_q[0][4]);
          check("retries_used", retries_used, exp_q[0][3:2]);
          check("err_code", err_code, exp_q[0][1:0]);
          void'(exp_q.pop_front());
          check("done_cycle", cyc, (exp_done_cyc_q.size() != 0) ? exp_done_cyc_q.pop_front() : -1);
        end
      end
      start_prev <= start_tx;
      done_prev  <= done;
    end else begin
      start_prev <= 1'b0;
      done_prev  <= 1'b0;
    end
  end

  // Driver tasks
  task automatic do_reset(input bit chk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    tx_busy = 1'b0;
    rx_done = 1'b0;
    #1;
    exp_q.delete();
    exp_start_cyc_q.delete();
    exp_byte_q.delete();
    exp_done_cyc_q.delete();
    exp_ok = 0;
    exp_fail = 0;
    exp_retry = 0;
    if (chk) begin
      check("rst_start_tx", start_tx, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_retries", retries_used, 0);
      check("rst_err", err_code, 0);
      check("rst_data_to_tx", data_to_tx, 0);
    end
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] b);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data = b;
    exp_start_cyc_q.push_back(cyc + 1);
    exp_byte_q.push_back(b);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] b);
    int n_att, k, c, r, d, f;
    logic [4:0] e;
    e = ref_result(n_att);
    exp_q.push_back(e);
    issue(b);
    for (int i = 0; i < n_att; i++) begin
      k = 0;
      while (!start_tx && k < T + G + 20) begin
        @(negedge clk);
        k++;
      end
      if (!start_tx) begin
        check("start_tx_seen", start_tx, 1);
        do_reset(1'b0);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      tx_busy = 1'b1;
      repeat ($urandom_range(2, 5)) begin
        @(negedge clk);
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_data = 8'($urandom);
      end
      cmd_valid = 1'b0;
      tx_busy = 1'b0;
      c = cyc;
      if (plan[i] == B_TO) begin
        f = c + 1 + T;
        if (i == n_att - 1) exp_done_cyc_q.push_back(f);
        else begin
          exp_start_cyc_q.push_back(f + G);
          exp_byte_q.push_back(b);
        end
      end else begin
        d = (force_d || $urandom_range(0, 4) == 0) ? T : $urandom_range(1, T - 1);
        repeat (d) @(negedge clk);
        rx_done = 1'b1;
        parity_error = (plan[i] == B_PAR);
        data_received = (plan[i] == B_MIS) ? (b ^ 8'($urandom_range(1, 255))) : b;
        r = cyc;
        f = r + 1;
        if (i == n_att - 1) exp_done_cyc_q.push_back(f);
        else begin
          exp_start_cyc_q.push_back(f + G);
          exp_byte_q.push_back(b);
        end
        @(negedge clk);
        rx_done = 1'b0;
        parity_error = 1'($urandom);
        data_received = 8'($urandom);
      end
      if (i != n_att - 1 && $urandom_range(0, 1) == 1) begin
        // A correct late echo inside the gap must not end the command.
        while (cyc < f + 1) @(negedge clk);
        rx_done = 1'b1;
        parity_error = 1'b0;
        data_received = b;
        @(negedge clk);
        rx_done = 1'b0;
      end
    end
    k = 0;
    while (!done && k < T + 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("done_seen", done, 1);
      do_reset(1'b0);
      return;
    end
    @(negedge clk);
    if (e[4]) exp_ok++;
    else exp_fail++;
    exp_retry += n_att - 1;
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    plan[0] = p0;
    plan[1] = p1;
    plan[2] = p2;
    plan[3] = p3;
  endtask

  initial begin
    int x;
    do_reset(1'b1);
    mon_en = 1'b1;

    set_plan(B_GOOD, B_GOOD, B_GOOD, B_GOOD);
    run_cmd(8'hEE);
    set_plan(B_MIS, B_MIS, B_MIS, B_MIS);
    run_cmd(8'hC3);
    do_reset(1'b1);
    set_plan(B_TO, B_TO, B_TO, B_TO);
    run_cmd(8'h3C);
    set_plan(B_PAR, B_GOOD, B_GOOD, B_GOOD);
    run_cmd(8'h5A);

    // Echo on the exact timeout clock
    force_d = 1'b1;
    set_plan(B_GOOD, B_GOOD, B_GOOD, B_GOOD);
    run_cmd(8'h81);
    set_plan(B_MIS, B_GOOD, B_GOOD, B_GOOD);
    run_cmd(8'h7E);
    force_d = 1'b0;

    // Reset while start_tx is high, then during ECHO_WAIT
    issue(8'h99);
    do_reset(1'b1);
    issue(8'hA5);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    do_reset(1'b1);
    rx_done = 1'b1;
    data_received = 8'hA5;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_done", done, 0);
      check("stray_ready", cmd_ready, 1);
    end
    set_plan(B_GOOD, B_GOOD, B_GOOD, B_GOOD);
    run_cmd(8'h01);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        x = $urandom_range(0, 9);
        plan[i] = (x < 5) ? B_GOOD : (x < 7) ? B_MIS : (x < 8) ? B_PAR : B_TO;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        rx_done = 1'b1;
        data_received = 8'($urandom);
        @(negedge clk);
        rx_done = 1'b0;
      end
      run_cmd(8'($urandom));
    end

    repeat (3) @(negedge clk);
`ifdef UART_ECHO_STATS_EN
    check("stat_ok", stat_ok, exp_ok);
    check("stat_fail", stat_fail, exp_fail);
    check("stat_retry", stat_retry, exp_retry);
`endif
    check("results_pending", exp_q.size(), 0);
    check("starts_pending", exp_start_cyc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
